// File: rtl/svc_rv_ext_fp_wb.sv
// svc_rv_ext_fp_wb: RV32F writeback/retire stage with in-order result buffer, sticky fflags and frm CSR
// Ports: ex_* accepts EX results (valid/ready); fp_rf_* writes the FP register file;
// int_rf_* requests/gets the shared integer write port; fp_pending marks buffered FP targets;
// csr_* software writes of fflags/frm; fflags/frm are the architectural CSR values.
// Define SVC_RV_EXT_FP_WB_BYPASS_EN to let results write back in the same cycle when the buffer is empty.
module svc_rv_ext_fp_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [4:0]  ex_fflags,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_fp,
  output logic        fp_rf_we,
  output logic [4:0]  fp_rf_waddr,
  output logic [31:0] fp_rf_wdata,
  output logic        int_rf_req,
  output logic [4:0]  int_rf_waddr,
  output logic [31:0] int_rf_wdata,
  input  logic        int_rf_gnt,
  output logic [31:0] fp_pending,
  input  logic        csr_fflags_we,
  input  logic [4:0]  csr_fflags_wdata,
  input  logic        csr_frm_we,
  input  logic [2:0]  csr_frm_wdata,
  output logic [4:0]  fflags,
  output logic [2:0]  frm
);
  localparam int AW = $clog2(DEPTH);
`ifdef SVC_RV_EXT_FP_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  fflags;
    logic [4:0]  rd;
    logic        rd_fp;
  } entry_t;
  entry_t        buf_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, off;
  logic [AW:0]   cnt_q, cnt_d;
  logic [4:0]    fflags_q, fflags_d;
  logic [2:0]    frm_q;
  entry_t        head, src;
  logic          empty, use_ex, byp, deq, enq, act;
  always_comb begin
    empty = cnt_q == '0;
    head = buf_q[rptr_q];
    ex_ready = cnt_q != (AW+1)'(DEPTH);
    // with bypass, an empty buffer presents the live EX result on the writeback ports
    use_ex = BYP && empty && ex_valid;
    src = use_ex ? {ex_result, ex_fflags, ex_rd, ex_rd_fp} : head;
    byp = use_ex && (ex_rd_fp || int_rf_gnt);
    deq = !empty && (head.rd_fp || int_rf_gnt);
    enq = ex_valid && ex_ready && !byp;
    act = use_ex || !empty;
    fp_rf_we = act && src.rd_fp;
    int_rf_req = act && !src.rd_fp;
    fp_rf_waddr = fp_rf_we ? src.rd : '0;
    fp_rf_wdata = fp_rf_we ? src.result : '0;
    int_rf_waddr = int_rf_req ? src.rd : '0;
    int_rf_wdata = int_rf_req ? src.result : '0;
    fflags_d = (csr_fflags_we ? csr_fflags_wdata : fflags_q)
             | (deq ? head.fflags : '0) | (byp ? ex_fflags : '0);
    cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
    fp_pending = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // entry i is live when its distance from the head is below count
      off = AW'(i) - rptr_q;
      if ({1'b0, off} < cnt_q && buf_q[i].rd_fp) fp_pending[buf_q[i].rd] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      fflags_q <= '0;
      frm_q <= '0;
    end else begin
      if (enq) begin
        buf_q[wptr_q] <= {ex_result, ex_fflags, ex_rd, ex_rd_fp};
        wptr_q <= wptr_q + AW'(1);
      end
      if (deq) rptr_q <= rptr_q + AW'(1);
      if (csr_frm_we) frm_q <= csr_frm_wdata;
      cnt_q <= cnt_d;
      fflags_q <= fflags_d;
    end
  end
  assign fflags = fflags_q;
  assign frm = frm_q;
endmodule
